// File: rtl/cpu_bus_cdc_requester_if.sv
// CPU bus and toggle-handshake signals for the requester side of the bus CDC bridge.
// master = the requester; slave = the CPU plus the far-side responder.
interface cpu_bus_cdc_requester_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  halt_o;
    logic                  req_toggle_o;
    logic [ADDR_WIDTH-1:0] req_addr_o;
    logic                  req_we_o;
    logic [DATA_WIDTH-1:0] req_data_o;
    logic                  ack_toggle_i;
    logic [DATA_WIDTH-1:0] ack_rdata_i;

    modport master (
        input  address_i, we_i, data_i, ack_toggle_i, ack_rdata_i,
        output data_o, halt_o, req_toggle_o, req_addr_o, req_we_o, req_data_o
    );

    modport slave (
        output address_i, we_i, data_i, ack_toggle_i, ack_rdata_i,
        input  data_o, halt_o, req_toggle_o, req_addr_o, req_we_o, req_data_o
    );
endinterface

// File: rtl/cpu_bus_cdc_requester.sv
// CPU-domain half of the bus CDC bridge: captures in-window accesses, launches them over a
// toggle request/ack handshake and stalls the CPU until the synchronized ack returns.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no access outstanding; a window hit launches a request
// WAIT    | request launched, CPU halted until synchronized ack matches
// RELEASE | one-cycle release; bus ignored, read data presented on data_o
module cpu_bus_cdc_requester #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 'h9100,
    parameter logic [ADDR_WIDTH-1:0] END_ADDR    = 'h91FF,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    cpu_bus_cdc_requester_if.master        bus
);

    if (SYNC_STAGES < 2) begin : g_sync_check
        $error("SYNC_STAGES must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    req_toggle_q, req_toggle_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic                    req_we_q, req_we_d;
    logic [DATA_WIDTH-1:0]   req_data_q, req_data_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q, ack_sync_d;

    logic hit;
    logic ack_synced;

    assign hit        = (bus.address_i >= START_ADDR) && (bus.address_i <= END_ADDR);
    assign ack_synced = ack_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            req_toggle_q <= 1'b0;
            req_addr_q   <= '0;
            req_we_q     <= 1'b0;
            req_data_q   <= '0;
            rdata_q      <= '0;
            ack_sync_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_toggle_q <= req_toggle_d;
            req_addr_q   <= req_addr_d;
            req_we_q     <= req_we_d;
            req_data_q   <= req_data_d;
            rdata_q      <= rdata_d;
            ack_sync_q   <= ack_sync_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_toggle_d = req_toggle_q;
        req_addr_d   = req_addr_q;
        req_we_d     = req_we_q;
        req_data_d   = req_data_q;
        rdata_d      = rdata_q;
        ack_sync_d   = {ack_sync_q[SYNC_STAGES-2:0], bus.ack_toggle_i};

        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    req_toggle_d = ~req_toggle_q;
                    req_addr_d   = bus.address_i;
                    req_we_d     = bus.we_i;
                    req_data_d   = bus.data_i;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // req_toggle_q already holds the ack value the far side will return
                if (ack_synced == req_toggle_q) begin
                    if (!req_we_q) begin
                        rdata_d = bus.ack_rdata_i;
                    end
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // halt is forced low while reset is held, even if an in-window address is presented
    assign bus.halt_o       = !reset_i && (((state_q == ST_IDLE) && hit) || (state_q == ST_WAIT));
    assign bus.data_o       = ((state_q == ST_RELEASE) && !req_we_q) ? rdata_q : '0;
    assign bus.req_toggle_o = req_toggle_q;
    assign bus.req_addr_o   = req_addr_q;
    assign bus.req_we_o     = req_we_q;
    assign bus.req_data_o   = req_data_q;

endmodule

// File: tb/tb_cpu_bus_cdc_requester.sv
// Directed, table-driven bench for cpu_bus_cdc_requester; the bench plays both the CPU
// and the far-side responder.
module tb_cpu_bus_cdc_requester;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cpu_bus_cdc_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    cpu_bus_cdc_requester #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .START_ADDR (32'h9100),
        .END_ADDR   (32'h91FF),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic        hit;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];
    int   n_total = 0;
    int   n_pass  = 0;
    logic exp_tog = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic do_access(input vec_t v);
        int cnt;
        bus.address_i = v.addr;
        bus.we_i      = v.we;
        bus.data_i    = v.wdata;
        #1;
        chk("halt_on_present", {31'd0, bus.halt_o}, {31'd0, v.hit});
        chk("data_before", bus.data_o, 32'h0);
        if (v.hit) begin
            step();
            exp_tog = ~exp_tog;
            chk("launch_toggle", {31'd0, bus.req_toggle_o}, {31'd0, exp_tog});
            chk("launch_addr", bus.req_addr_o, v.addr);
            chk("launch_we", {31'd0, bus.req_we_o}, {31'd0, v.we});
            chk("launch_data", bus.req_data_o, v.wdata);
            // address moves away during WAIT; the captured request must still complete
            bus.address_i = 32'h0;
            for (int i = 0; i < v.lat; i++) begin
                step();
                chk("wait_halt", {31'd0, bus.halt_o}, 32'd1);
            end
            bus.ack_rdata_i  = v.rdata;
            bus.ack_toggle_i = exp_tog;
            cnt = 0;
            while (bus.halt_o && cnt < 10) begin
                step();
                cnt++;
            end
            chk("ack_to_release_cycles", cnt, 32'd3);
            chk("release_data", bus.data_o, v.exp_data);
            chk("held_addr", bus.req_addr_o, v.addr);
            chk("held_toggle", {31'd0, bus.req_toggle_o}, {31'd0, exp_tog});
            step();
            chk("data_after", bus.data_o, 32'h0);
            chk("halt_after", {31'd0, bus.halt_o}, 32'd0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                step();
                chk("miss_halt", {31'd0, bus.halt_o}, 32'd0);
                chk("miss_toggle", {31'd0, bus.req_toggle_o}, {31'd0, exp_tog});
                chk("miss_data", bus.data_o, 32'h0);
            end
        end
        bus.address_i = 32'h0;
        bus.we_i      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        //          addr          we    wdata          rdata          lat hit   exp_data
        vecs[0] = '{32'h0000_9100, 1'b1, 32'hDEADBEEF, 32'h0000_0000, 2, 1'b1, 32'h0};
        vecs[1] = '{32'h0000_9100, 1'b0, 32'h0000_0000, 32'h12345678, 1, 1'b1, 32'h12345678};
        vecs[2] = '{32'h0000_9004, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 32'h0};
        vecs[3] = '{32'h0000_91FF, 1'b0, 32'h0000_0000, 32'hA5A5_0001, 0, 1'b1, 32'hA5A5_0001};
        vecs[4] = '{32'h0000_9200, 1'b1, 32'h0BAD_0BAD, 32'h0000_0000, 0, 1'b0, 32'h0};
        vecs[5] = '{32'h0000_90FF, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 32'h0};
        vecs[6] = '{32'h0000_9180, 1'b1, 32'h0000_1234, 32'h0000_FFFF, 3, 1'b1, 32'h0};
        vecs[7] = '{32'hFFFF_9100, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 32'h0};

        // reset state, with an in-window address presented while reset is held
        bus.address_i    = 32'h9100;
        bus.we_i         = 1'b0;
        bus.data_i       = 32'h0;
        bus.ack_toggle_i = 1'b0;
        bus.ack_rdata_i  = 32'h0;
        step();
        step();
        chk("rst_halt", {31'd0, bus.halt_o}, 32'd0);
        chk("rst_toggle", {31'd0, bus.req_toggle_o}, 32'd0);
        chk("rst_addr", bus.req_addr_o, 32'h0);
        chk("rst_we", {31'd0, bus.req_we_o}, 32'd0);
        chk("rst_wdata", bus.req_data_o, 32'h0);
        chk("rst_data_o", bus.data_o, 32'h0);
        bus.address_i = 32'h0;
        #2 rst = 1'b0;
        step();

        for (int k = 0; k < 8; k++) do_access(vecs[k]);

        // address held at 0x9100 across completion: one toggle per access, next only after RELEASE
        bus.address_i = 32'h9100;
        bus.we_i      = 1'b0;
        step();
        exp_tog = ~exp_tog;
        chk("hold_launch1", {31'd0, bus.req_toggle_o}, {31'd0, exp_tog});
        step();
        bus.ack_rdata_i  = 32'h1111_2222;
        bus.ack_toggle_i = exp_tog;
        step();
        step();
        chk("hold_still_wait", {31'd0, bus.halt_o}, 32'd1);
        step();
        chk("hold_release_halt", {31'd0, bus.halt_o}, 32'd0);
        chk("hold_release_data", bus.data_o, 32'h1111_2222);
        chk("hold_release_toggle", {31'd0, bus.req_toggle_o}, {31'd0, exp_tog});
        step();
        chk("hold_idle_halt", {31'd0, bus.halt_o}, 32'd1);
        chk("hold_idle_toggle", {31'd0, bus.req_toggle_o}, {31'd0, exp_tog});
        chk("hold_idle_data", bus.data_o, 32'h0);
        step();
        exp_tog = ~exp_tog;
        chk("hold_launch2", {31'd0, bus.req_toggle_o}, {31'd0, exp_tog});
        bus.address_i    = 32'h0;
        bus.ack_rdata_i  = 32'h3333_4444;
        bus.ack_toggle_i = exp_tog;
        cnt = 0;
        while (bus.halt_o && cnt < 10) begin
            step();
            cnt++;
        end
        chk("hold_second_release", cnt, 32'd3);
        chk("hold_second_data", bus.data_o, 32'h3333_4444);
        step();

        // reset asserted mid-WAIT with the access address still presented
        bus.address_i = 32'h9120;
        bus.we_i      = 1'b0;
        step();
        exp_tog = ~exp_tog;
        chk("rw_launch", {31'd0, bus.req_toggle_o}, {31'd0, exp_tog});
        step();
        chk("rw_wait_halt", {31'd0, bus.halt_o}, 32'd1);
        rst = 1'b1;
        bus.ack_toggle_i = 1'b0;
        exp_tog = 1'b0;
        #1;
        chk("rw_halt", {31'd0, bus.halt_o}, 32'd0);
        chk("rw_toggle", {31'd0, bus.req_toggle_o}, 32'd0);
        chk("rw_addr", bus.req_addr_o, 32'h0);
        chk("rw_we", {31'd0, bus.req_we_o}, 32'd0);
        chk("rw_wdata", bus.req_data_o, 32'h0);
        chk("rw_data_o", bus.data_o, 32'h0);
        bus.address_i = 32'h0;
        step();
        step();
        #2 rst = 1'b0;
        step();
        do_access('{32'h0000_9104, 1'b0, 32'h0, 32'hCAFEF00D, 1, 1'b1, 32'hCAFEF00D});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
